fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipeline.
- Generates per-operand EX forwarding selects for NUM_SRC source operands, with a fixed priority: nearest producer wins.
- Detects load-use hazards and stalls ID for them.
- Tracks one in-flight multi-cycle ALU operation (mul/div) with a countdown FSM. Stalls ID on RAW/WAW against its destination and on structural conflict.
- Sits beside the ID/EX pipeline registers. Drives the EX operand muxes and the PC/IF-ID hold.

Parameters:
- REG_AW, 4, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- MC_LAT, 4, multi-cycle unit latency in cycles (>=2).
- ZERO_REG_EN, 1, when 1, register 0 is never forwarded and never causes a hazard.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_src  in  NUM_SRC*REG_AW  ID source register numbers; operand i is bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  operand i is actually read.
- id_wr  in  1  ID instruction writes a register.
- id_dst  in  REG_AW  ID destination register.
- id_mc  in  1  ID instruction is a multi-cycle op.
- ex_src  in  NUM_SRC*REG_AW  EX source register numbers.
- ex_wr, ex_is_load  in  1 each  EX writes a register / is a load.
- ex_dst  in  REG_AW  EX destination register.
- mem_wr  in  1  MEM writes a register.
- mem_dst  in  REG_AW  MEM destination register.
- wb_wr  in  1  WB writes a register.
- wb_dst  in  REG_AW  WB destination register.
- fwd_sel  out  NUM_SRC*2  per operand: 00 regfile, 01 MEM, 10 WB, 11 MC result.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- mc_busy  out  1  multi-cycle unit occupied (state BUSY).
- mc_done  out  1  one-cycle pulse; MC result valid, written to the regfile at end of this cycle.
- mc_dst  out  REG_AW  destination of the in-flight MC op.
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset values (async on rst=1): state IDLE, counter 0, mc_dst 0, stall_cnt 0, mc_busy 0, mc_done 0. Combinational outputs are derived from the reset state: stall 0, fwd_sel all 00 unless the inputs match.
- Reg-zero rule: with ZERO_REG_EN=1, any address equal to 0 never matches in any comparison.
- fwd_sel is combinational, evaluated per operand i, first match wins:
  - mem_wr && mem_dst==ex_src[i] -> 01
  - else wb_wr && wb_dst==ex_src[i] -> 10
  - else state==DONE && mc_dst==ex_src[i] -> 11
  - else 00
- Load-use hazard: id_valid && ex_is_load && ex_wr && for some i, id_src_used[i] && id_src[i]==ex_dst.
- MC RAW hazard: state==BUSY && for some i, id_src_used[i] && id_src[i]==mc_dst.
- MC WAW hazard: state==BUSY && id_wr && id_dst==mc_dst.
- MC structural hazard: state==BUSY && id_mc.
- stall = id_valid && (any of the four hazards above). stall is combinational.
- MC accept: id_valid && id_mc && !stall, in state IDLE or DONE.
- FSM:
  - IDLE: on accept -> BUSY; counter = MC_LAT-1; mc_dst <= id_dst.
  - BUSY: counter decrements each cycle; when counter==1 -> DONE. Result: mc_done asserts exactly MC_LAT cycles after the accept edge.
  - DONE: mc_done=1 for one cycle. On accept -> BUSY (back-to-back issue, new mc_dst loaded); otherwise -> IDLE.
- mc_dst holds its value through DONE and until the next accept.
- stall_cnt: increments on every clock edge where stall=1; saturates at all-ones.
- Simultaneous events:
  - Load-use and MC hazards together -> a single stall; stall_cnt increments by 1.
  - Accept in DONE with the same mc_dst -> legal; the new op overwrites mc_dst.
- Reset mid-operation aborts the MC op. mc_done is not produced for it.

Decomposition:
- Shared package (hazard_pkg):
  - fwd_sel encodings FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, FWD_MC=2'b11.
  - MC FSM state enum {IDLE, BUSY, DONE}.
- One natural sub-module: mc_tracker, holding the FSM, counter and mc_dst register, with outputs mc_busy, mc_done, mc_dst and in_done.
- Forwarding compare, hazard OR-reduction and stall_cnt stay in the top level, generated over NUM_SRC.

Test Plan:
- Forward priority: mem_wr=1, mem_dst=3; wb_wr=1, wb_dst=3; ex_src0=3 -> fwd_sel[1:0]=01. Drop mem_wr -> 10. Drop wb_wr as well -> 00.
- Load-use: ex_is_load=1, ex_wr=1, ex_dst=5; id_src1=5 with id_src_used[1]=1 -> stall=1, stall_cnt 0->1. Clear id_src_used[1] -> stall=0.
- MC latency: MC_LAT=4, accept with id_dst=7 at edge 0 -> mc_busy=1 for cycles 1-3, mc_done=1 at cycle 4 only. With ex_src0=7 at cycle 4 -> fwd_sel=11.
- MC hazards during BUSY (mc_dst=7): id_src0=7 used -> stall. id_wr=1 with id_dst=7 -> stall. id_mc=1 -> stall. Unrelated instruction -> stall=0.
- Back-to-back: accept in the DONE cycle with id_dst=2 -> state BUSY, mc_dst=2, next mc_done exactly 4 cycles later. Register 0: ex_src0=0, mem_wr=1, mem_dst=0 -> fwd_sel=00.
- Reset mid-BUSY: assert rst asynchronously at cycle 2 -> mc_busy=0 immediately, stall_cnt=0, no mc_done afterwards. Saturation: STALL_CNT_W=4, hold stall 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand-mux selects and MC tracker states.
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_MC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

endpackage

`default_nettype wire

// File: rtl/mc_tracker.sv
// Tracks one in-flight multi-cycle ALU op: countdown FSM plus its destination register.
`default_nettype none

module mc_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  input  logic [REG_AW-1:0] dst_i,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [REG_AW-1:0] mc_dst_o,
  output logic              in_done_o
);

  localparam int CNT_W = $clog2(MC_LAT + 1);

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] dst_q, dst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  // Loading MC_LAT-1 and leaving BUSY when the count reaches 1 puts DONE
  // exactly MC_LAT cycles after the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_i) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MC_LAT - 1);
          dst_d   = dst_i;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mc_busy_o = (state_q == BUSY);
  assign mc_done_o = (state_q == DONE);
  assign in_done_o = (state_q == DONE);
  assign mc_dst_o  = dst_q;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects, load-use / multi-cycle hazard stall and stall counter.
`default_nettype none

module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int NUM_SRC     = 2,
  parameter int MC_LAT      = 4,
  parameter int ZERO_REG_EN = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic                      id_wr_i,
  input  logic [REG_AW-1:0]         id_dst_i,
  input  logic                      id_mc_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
  input  logic                      ex_wr_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_AW-1:0]         ex_dst_i,
  input  logic                      mem_wr_i,
  input  logic [REG_AW-1:0]         mem_dst_i,
  input  logic                      wb_wr_i,
  input  logic [REG_AW-1:0]         wb_dst_i,
  output logic [NUM_SRC*2-1:0]      fwd_sel_o,
  output logic                      stall_o,
  output logic                      mc_busy_o,
  output logic                      mc_done_o,
  output logic [REG_AW-1:0]         mc_dst_o,
  output logic [STALL_CNT_W-1:0]    stall_cnt_o
);

  logic               mc_accept;
  logic               mc_in_done;
  logic [NUM_SRC-1:0] lu_hit;
  logic [NUM_SRC-1:0] raw_hit;
  logic               haz_lu, haz_raw, haz_waw, haz_struct;
  logic               dst_nz;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_AW-1:0] ex_a;
    logic [REG_AW-1:0] id_a;
    logic              ex_nz;
    logic              id_nz;
    logic [1:0]        sel;

    assign ex_a  = ex_src_i[g*REG_AW +: REG_AW];
    assign id_a  = id_src_i[g*REG_AW +: REG_AW];
    // Masking one side of each equality is enough: a match implies both are zero.
    assign ex_nz = (ZERO_REG_EN == 0) || (ex_a != '0);
    assign id_nz = (ZERO_REG_EN == 0) || (id_a != '0);

    always_comb begin
      sel = FWD_RF;
      if (ex_nz && mem_wr_i && (mem_dst_i == ex_a)) begin
        sel = FWD_MEM;
      end else if (ex_nz && wb_wr_i && (wb_dst_i == ex_a)) begin
        sel = FWD_WB;
      end else if (ex_nz && mc_in_done && (mc_dst_o == ex_a)) begin
        sel = FWD_MC;
      end
    end

    assign fwd_sel_o[g*2 +: 2] = sel;
    assign lu_hit[g]  = id_nz && id_src_used_i[g] && (id_a == ex_dst_i);
    assign raw_hit[g] = id_nz && id_src_used_i[g] && (id_a == mc_dst_o);
  end

  assign dst_nz     = (ZERO_REG_EN == 0) || (id_dst_i != '0);
  assign haz_lu     = ex_is_load_i && ex_wr_i && (|lu_hit);
  assign haz_raw    = mc_busy_o && (|raw_hit);
  assign haz_waw    = mc_busy_o && id_wr_i && dst_nz && (id_dst_i == mc_dst_o);
  assign haz_struct = mc_busy_o && id_mc_i;
  assign stall_o    = id_valid_i && (haz_lu || haz_raw || haz_waw || haz_struct);
  assign mc_accept  = id_valid_i && id_mc_i && !stall_o;

  mc_tracker #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT)
  ) u_mc_tracker (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (mc_accept),
    .dst_i     (id_dst_i),
    .mc_busy_o (mc_busy_o),
    .mc_done_o (mc_done_o),
    .mc_dst_o  (mc_dst_o),
    .in_done_o (mc_in_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (default build plus a 4-bit stall counter build).
`timescale 1ns/1ps
`default_nettype none

module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic       id_wr;
  logic [3:0] id_dst;
  logic       id_mc;
  logic [7:0] ex_src;
  logic       ex_wr;
  logic       ex_is_load;
  logic [3:0] ex_dst;
  logic       mem_wr;
  logic [3:0] mem_dst;
  logic       wb_wr;
  logic [3:0] wb_dst;

  logic [3:0]  fwd_sel;
  logic        stall, mc_busy, mc_done;
  logic [3:0]  mc_dst;
  logic [15:0] stall_cnt;

  logic [3:0]  s_fwd_sel;
  logic        s_stall, s_mc_busy, s_mc_done;
  logic [3:0]  s_mc_dst;
  logic [3:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_src_i(id_src),
    .id_src_used_i(id_src_used), .id_wr_i(id_wr), .id_dst_i(id_dst), .id_mc_i(id_mc),
    .ex_src_i(ex_src), .ex_wr_i(ex_wr), .ex_is_load_i(ex_is_load), .ex_dst_i(ex_dst),
    .mem_wr_i(mem_wr), .mem_dst_i(mem_dst), .wb_wr_i(wb_wr), .wb_dst_i(wb_dst),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .mc_busy_o(mc_busy), .mc_done_o(mc_done),
    .mc_dst_o(mc_dst), .stall_cnt_o(stall_cnt)
  );

  fwd_hazard_unit #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_src_i(id_src),
    .id_src_used_i(id_src_used), .id_wr_i(id_wr), .id_dst_i(id_dst), .id_mc_i(id_mc),
    .ex_src_i(ex_src), .ex_wr_i(ex_wr), .ex_is_load_i(ex_is_load), .ex_dst_i(ex_dst),
    .mem_wr_i(mem_wr), .mem_dst_i(mem_dst), .wb_wr_i(wb_wr), .wb_dst_i(wb_dst),
    .fwd_sel_o(s_fwd_sel), .stall_o(s_stall), .mc_busy_o(s_mc_busy), .mc_done_o(s_mc_done),
    .mc_dst_o(s_mc_dst), .stall_cnt_o(s_stall_cnt)
  );

  task automatic clear_inputs();
    id_valid = 0; id_src = '0; id_src_used = '0; id_wr = 0; id_dst = '0; id_mc = 0;
    ex_src = '0; ex_wr = 0; ex_is_load = 0; ex_dst = '0;
    mem_wr = 0; mem_dst = '0; wb_wr = 0; wb_dst = '0;
  endtask

  // Present an MC instruction in the current cycle; returns #1 after the accepting edge.
  task automatic issue_mc(input logic [3:0] dst);
    @(negedge clk);
    id_valid = 1; id_mc = 1; id_wr = 1; id_dst = dst; id_src_used = '0;
    @(posedge clk);
    #1;
    id_valid = 0; id_mc = 0; id_wr = 0; id_dst = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #12;
    checks++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mc_busy); end
    checks++; if (mc_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", mc_done); end
    checks++; if (mc_dst !== 4'd0) begin errors++; $display("FAIL reset_mc_dst: got %0d want 0", mc_dst); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    checks++; if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL reset_comb: stall=%b fwd=%b want 0/0000", stall, fwd_sel);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    ex_src = {4'd9, 4'd3}; mem_wr = 1; mem_dst = 4'd3; wb_wr = 1; wb_dst = 4'd3;
    #1;
    checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_mem_first: got %b want 0001", fwd_sel); end
    mem_wr = 0; #1;
    checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL fwd_wb: got %b want 0010", fwd_sel); end
    wb_wr = 0; #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_none: got %b want 0000", fwd_sel); end
    mem_wr = 1; mem_dst = 4'd9; wb_wr = 1; wb_dst = 4'd3; #1;
    checks++; if (fwd_sel !== 4'b0110) begin errors++; $display("FAIL fwd_mixed: got %b want 0110", fwd_sel); end
    ex_src = '0; mem_dst = 4'd0; wb_dst = 4'd0; #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_reg0: got %b want 0000", fwd_sel); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    id_valid = 1; ex_is_load = 1; ex_wr = 1; ex_dst = 4'd5;
    id_src = {4'd5, 4'd1}; id_src_used = 2'b10;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
    @(negedge clk);
    exp_cnt = 1;
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    id_src_used = 2'b01; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused: got %b want 0", stall); end
    id_src_used = 2'b10; ex_is_load = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_notload: got %b want 0", stall); end
    clear_inputs();
    @(negedge clk);
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_cnt_hold: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_mc_latency();
    issue_mc(4'd7);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (mc_busy !== (k < 4) || mc_done !== (k == 4)) begin
        errors++; $display("FAIL mc_lat_c%0d: busy=%b done=%b want %b/%b", k, mc_busy, mc_done, k < 4, k == 4);
      end
      if (k == 4) begin
        ex_src = {4'd1, 4'd7}; #1;
        checks++; if (fwd_sel !== 4'b0011 || mc_dst !== 4'd7) begin
          errors++; $display("FAIL mc_fwd: fwd=%b dst=%0d want 0011/7", fwd_sel, mc_dst);
        end
      end
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (mc_busy !== 1'b0 || mc_done !== 1'b0 || fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL mc_idle: busy=%b done=%b fwd=%b want 0/0/0000", mc_busy, mc_done, fwd_sel);
    end
  endtask

  task automatic test_mc_hazards();
    bit seen;
    issue_mc(4'd7);
    @(negedge clk);
    id_valid = 1; id_src = {4'd0, 4'd7}; id_src_used = 2'b01; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mc_raw: got %b want 1", stall); end
    id_src_used = 2'b00; id_wr = 1; id_dst = 4'd7; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mc_waw: got %b want 1", stall); end
    id_wr = 0; id_mc = 1; id_dst = 4'd3; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mc_struct: got %b want 1", stall); end
    id_mc = 0; id_wr = 1; id_dst = 4'd4; id_src = {4'd2, 4'd3}; id_src_used = 2'b11; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc_unrelated: got %b want 0", stall); end
    @(negedge clk);
    // Load-use and MC RAW at once must count a single stall cycle.
    id_wr = 0; ex_is_load = 1; ex_wr = 1; ex_dst = 4'd7; id_src = {4'd7, 4'd7}; id_src_used = 2'b11;
    @(negedge clk);
    exp_cnt++;
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL dual_haz_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    clear_inputs();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mc_done === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mc_haz_done: got timeout want done"); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue_mc(4'd9);
    repeat (4) @(negedge clk);
    checks++; if (mc_done !== 1'b1 || mc_dst !== 4'd9) begin
      errors++; $display("FAIL b2b_first_done: done=%b dst=%0d want 1/9", mc_done, mc_dst);
    end
    id_valid = 1; id_mc = 1; id_wr = 1; id_dst = 4'd2; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_accept_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    clear_inputs();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (mc_busy !== (k < 4) || mc_done !== (k == 4) || mc_dst !== 4'd2) begin
        errors++; $display("FAIL b2b_c%0d: busy=%b done=%b dst=%0d want %b/%b/2", k, mc_busy, mc_done, mc_dst, k < 4, k == 4);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    id_valid = 1; ex_is_load = 1; ex_wr = 1; ex_dst = 4'd5; id_src = {4'd0, 4'd5}; id_src_used = 2'b01;
    repeat (20) @(negedge clk);
    exp_cnt += 20;
    clear_inputs();
    checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", s_stall_cnt); end
    checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL wide_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    @(negedge clk);
    checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); end
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    issue_mc(4'd6);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1;
    #1;
    checks++; if (mc_busy !== 1'b0 || mc_dst !== 4'd0) begin
      errors++; $display("FAIL rst_busy: busy=%b dst=%0d want 0/0", mc_busy, mc_dst);
    end
    checks++; if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_cnt: cnt=%0d sat=%0d want 0/0", stall_cnt, s_stall_cnt);
    end
    #1 rst = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mc_done !== 1'b0 || mc_busy !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_no_done: got activity want none"); end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_mc_latency();
    test_mc_hazards();
    test_back_to_back();
    test_saturation();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
